// File: rtl/ring_osc_freq_meter.sv
// Ring oscillator frequency meter: gates the oscillator, synchronises its output
// and counts rising edges over a programmable window of clk cycles.
module ring_osc_freq_meter #(
  parameter int unsigned GATE_W        = 16,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              osc_in,
  output logic              osc_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_e;

  state_e             state_q, state_d;
  logic [GATE_W-1:0]  gate_q, gate_d;
  logic [GATE_W-1:0]  win_q, win_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic               ovf_q, ovf_d;
  logic               osc_en_q, osc_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   edge_c;
  logic [CNT_W-1:0]       edge_cnt_inc;
  logic                   ovf_inc;

  // Synchroniser chain plus one history flop for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_c = sync_q[SYNC_STAGES-1] & ~hist_q;

  // Saturating edge counter update for the current cycle
  always_comb begin
    edge_cnt_inc = edge_cnt_q;
    ovf_inc      = ovf_q;
    if (edge_c) begin
      if (edge_cnt_q == CNT_MAX) begin
        ovf_inc = 1'b1;
      end else begin
        edge_cnt_inc = edge_cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gate_d     = gate_q;
    win_d      = win_q;
    settle_d   = settle_q;
    edge_cnt_d = edge_cnt_q;
    ovf_d      = ovf_q;
    osc_en_d   = osc_en_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    count_d    = count_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SETTLE;
          gate_d     = gate_len;
          settle_d   = '0;
          edge_cnt_d = '0;
          ovf_d      = 1'b0;
          osc_en_d   = 1'b1;
          busy_d     = 1'b1;
        end
      end
      SETTLE: begin
        if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
          if (gate_q == '0) begin
            state_d    = DONE;
            osc_en_d   = 1'b0;
            done_d     = 1'b1;
            count_d    = edge_cnt_q;
            overflow_d = ovf_q;
          end else begin
            state_d = MEASURE;
            win_d   = gate_q;
          end
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      MEASURE: begin
        edge_cnt_d = edge_cnt_inc;
        ovf_d      = ovf_inc;
        win_d      = win_q - GATE_W'(1);
        // Last window cycle: its own edge is folded into the latched result
        if (win_q == GATE_W'(1)) begin
          state_d    = DONE;
          osc_en_d   = 1'b0;
          done_d     = 1'b1;
          count_d    = edge_cnt_inc;
          overflow_d = ovf_inc;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d  = IDLE;
        osc_en_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gate_q     <= '0;
      win_q      <= '0;
      settle_q   <= '0;
      edge_cnt_q <= '0;
      ovf_q      <= 1'b0;
      osc_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_q     <= gate_d;
      win_q      <= win_d;
      settle_q   <= settle_d;
      edge_cnt_q <= edge_cnt_d;
      ovf_q      <= ovf_d;
      osc_en_q   <= osc_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign osc_en   = osc_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: doc/ring_osc_freq_meter.md
Name: ring_osc_freq_meter

Overview:
Sits directly downstream of the NAND-chain ring oscillator. It owns the oscillator enable, synchronises the free-running oscillator output into the system clock domain, and counts its rising edges over a programmable gate window of clk cycles. The result is latched as a saturating edge count for readout on the project's output pins.

Parameters:
GATE_W, 16, width of gate_len, the window length in clk cycles
CNT_W, 16, width of the edge counter and of count
SYNC_STAGES, 2, number of flops in the osc_in synchroniser (minimum 2)
SETTLE_CYCLES, 4, clk cycles with oscillator enabled before counting starts (minimum SYNC_STAGES+1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle measurement request
gate_len  input  GATE_W  window length in clk cycles; sampled on accepted start
osc_in  input  1  raw ring oscillator output, asynchronous to clk
osc_en  output  1  oscillator enable, drives the oscillator's en0
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse when count becomes valid
count  output  CNT_W  latched rising-edge count of the last measurement
overflow  output  1  last measurement saturated count

Behaviour:
- Reset values (asynchronous, rst_n low): state=IDLE; osc_en, busy, done and overflow = 0; count = 0; synchroniser flops = 0; internal counters = 0.
- Synchroniser: osc_in passes through SYNC_STAGES flops, then one history flop. A rising edge is detected when the last sync flop is 1 and the history flop is 0. There is at most one edge per clk cycle. Oscillator frequencies above clk/2 alias; that is documented, not detected.
- FSM states: IDLE, SETTLE, MEASURE, DONE.
- IDLE: osc_en=0, busy=0. If start=1, latch gate_len into gate_q, clear the edge counter and overflow, then go to SETTLE. busy=1 and osc_en=1 from the next cycle.
- SETTLE: osc_en=1. Run for exactly SETTLE_CYCLES cycles, then go to MEASURE. No edges are counted; this flushes stale synchroniser state.
- MEASURE: osc_en=1. Lasts exactly gate_q cycles. Every detected rising edge in those cycles increments the edge counter. The counter saturates at 2^CNT_W-1; an edge that arrives at saturation sets an internal ovf flag. After the last window cycle, go to DONE.
- If gate_q=0, MEASURE is skipped: SETTLE goes straight to DONE and the count is 0.
- DONE, held for one cycle: osc_en=0, done=1, count is loaded from the edge counter, overflow is loaded from ovf, and busy=0 from the next cycle. Next state is IDLE.
- Latency from the start cycle to the done pulse is 1 + SETTLE_CYCLES + gate_q cycles.
- start while busy is ignored: gate_len is not re-sampled and there is no restart.
- count and overflow hold their value until the next DONE. They are not cleared on start.
- Reset mid-operation forces IDLE immediately. osc_en drops asynchronously and count and overflow are cleared.
- osc_en is a registered output with no combinational path from start.

Test Plan:
- Reset, then idle: rst_n low for 3 cycles, then release with no start -> osc_en=0, busy=0, done=0, count=0, overflow=0, and all stay stable for 50 cycles.
- Basic measurement: osc_in toggles every 2 clk cycles (period 4) while osc_en=1; start with gate_len=100 -> done pulses exactly 105 cycles after start (SETTLE_CYCLES=4), count=25, overflow=0, busy low the cycle after done.
- Saturation: CNT_W=4, osc_in period 2 clk, gate_len=64 -> count=15, overflow=1. A following run with gate_len=8 -> count=4, overflow=0.
- Zero gate and ignored start: gate_len=0 -> done at cycle 5, count=0. A second start pulse with gate_len=7, issued during SETTLE of a gate_len=40 run, is ignored -> a single done at cycle 45.
- Reset mid-measure: assert rst_n low 20 cycles into MEASURE -> osc_en=0 immediately, no done pulse, count=0. A fresh start with gate_len=100 after release again yields count=25.
- Enable gating: osc_in held constant at 1, start with gate_len=30 -> count=0. osc_en is high for exactly 34 cycles, from the cycle after start through the last MEASURE cycle.
